// File: rtl/rle_capture_ctrl.sv
// Capture-side sequencer for rle_enc: forwards sampler data, counts encoder words
// against a post-trigger budget, then closes the open run and drains the encoder.
module rle_capture_ctrl #(
    parameter int LIMIT_W      = 16,
    parameter int RESERVE      = 4,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               arm,
    input  logic               abort,
    input  logic               trigger,
    input  logic               cfg_rle_en,
    input  logic [1:0]         cfg_rle_mode,
    input  logic [3:0]         cfg_groups,
    input  logic [LIMIT_W-1:0] cfg_limit,
    input  logic [31:0]        sample_data,
    input  logic               sample_valid,
    input  logic               enc_valid_out,
    output logic               enc_enable,
    output logic [1:0]         enc_mode,
    output logic [3:0]         enc_groups,
    output logic [31:0]        enc_data,
    output logic               enc_valid,
    output logic               busy,
    output logic               done,
    output logic [LIMIT_W-1:0] word_count
);

    // state  | meaning
    // IDLE   | waiting for arm
    // ARMED  | forwarding samples, waiting for trigger
    // RUN    | forwarding samples, counting encoder words
    // FLUSH  | one injected sample that closes the pending run
    // DRAIN  | encoder still enabled while its pipeline empties
    // DONE   | acquisition complete, waiting for arm or abort
    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_RUN, S_FLUSH, S_DRAIN, S_DONE
    } state_t;

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]      DRAIN_LOAD  = DW'(DRAIN_CYCLES - 1);
    localparam logic [LIMIT_W:0]   RESERVE_EXT = (LIMIT_W + 1)'(RESERVE);
    localparam logic [LIMIT_W-1:0] WC_ONE      = LIMIT_W'(1);

    state_t             state_q, state_d;
    logic               cfg_en_q, cfg_en_d;
    logic [LIMIT_W-1:0] limit_q, limit_d;
    logic [1:0]         mode_d;
    logic [3:0]         groups_d;
    logic [31:0]        last_data, last_data_d;
    logic               run_open, run_open_d;
    logic [DW-1:0]      drain_cnt, drain_cnt_d;
    logic [LIMIT_W-1:0] wc_d, wc_inc;
    logic [31:0]        enc_data_d;
    logic               enc_valid_d, enc_enable_d, busy_d, done_d;
    logic [31:0]        lane_mask;
    logic [LIMIT_W:0]   stop_sum;
    logic               stop_hit, fwd, active_d;

    // Byte lanes with a set group bit are ignored when comparing for a repeat.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < 4; i++) begin
            lane_mask[8*i +: 8] = {8{~enc_groups[i]}};
        end
    end

    assign stop_sum = {1'b0, word_count} + RESERVE_EXT;
    assign stop_hit = (stop_sum >= {1'b0, limit_q});
    assign wc_inc   = (&word_count) ? word_count : word_count + WC_ONE;

    always_comb begin
        state_d     = state_q;
        cfg_en_d    = cfg_en_q;
        mode_d      = enc_mode;
        groups_d    = enc_groups;
        limit_d     = limit_q;
        last_data_d = last_data;
        run_open_d  = run_open;
        drain_cnt_d = drain_cnt;
        wc_d        = word_count;
        enc_data_d  = enc_data;
        enc_valid_d = 1'b0;
        fwd         = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_d    = S_ARMED;
                    cfg_en_d   = cfg_rle_en;
                    mode_d     = cfg_rle_mode;
                    groups_d   = cfg_groups;
                    limit_d    = cfg_limit;
                    wc_d       = '0;
                    run_open_d = 1'b0;
                end
            end
            S_ARMED: begin
                fwd = 1'b1;
                if (trigger) state_d = S_RUN;
            end
            S_RUN: begin
                if (enc_valid_out) wc_d = wc_inc;
                if (stop_hit) begin
                    if (cfg_en_q && run_open) begin
                        state_d     = S_FLUSH;
                        enc_valid_d = 1'b1;
                        enc_data_d  = ~last_data;
                    end else begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = DRAIN_LOAD;
                    end
                end else begin
                    fwd = 1'b1;
                end
            end
            S_FLUSH: begin
                if (enc_valid_out) wc_d = wc_inc;
                state_d     = S_DRAIN;
                drain_cnt_d = DRAIN_LOAD;
            end
            S_DRAIN: begin
                if (enc_valid_out) wc_d = wc_inc;
                if (drain_cnt == '0) state_d = S_DONE;
                else drain_cnt_d = drain_cnt - DW'(1);
            end
            default: state_d = S_IDLE;
        endcase

        if (fwd && !abort) begin
            enc_valid_d = sample_valid;
            enc_data_d  = sample_data;
            if (sample_valid) begin
                run_open_d  = (((sample_data ^ last_data) & lane_mask) == '0);
                last_data_d = sample_data;
            end
        end

        // Abort overrides everything, including an arm in the same cycle.
        if (abort) begin
            state_d     = S_IDLE;
            cfg_en_d    = cfg_en_q;
            mode_d      = enc_mode;
            groups_d    = enc_groups;
            limit_d     = limit_q;
            run_open_d  = run_open;
            last_data_d = last_data;
            enc_data_d  = enc_data;
            enc_valid_d = 1'b0;
            wc_d        = '0;
        end

        active_d     = (state_d inside {S_ARMED, S_RUN, S_FLUSH, S_DRAIN});
        enc_enable_d = active_d & cfg_en_d;
        busy_d       = active_d;
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cfg_en_q   <= 1'b0;
            limit_q    <= '0;
            last_data  <= '0;
            run_open   <= 1'b0;
            drain_cnt  <= '0;
            word_count <= '0;
            enc_mode   <= '0;
            enc_groups <= '0;
            enc_data   <= '0;
            enc_valid  <= 1'b0;
            enc_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_en_q   <= cfg_en_d;
            limit_q    <= limit_d;
            last_data  <= last_data_d;
            run_open   <= run_open_d;
            drain_cnt  <= drain_cnt_d;
            word_count <= wc_d;
            enc_mode   <= mode_d;
            enc_groups <= groups_d;
            enc_data   <= enc_data_d;
            enc_valid  <= enc_valid_d;
            enc_enable <= enc_enable_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_rle_capture_ctrl.sv
// Directed bench for rle_capture_ctrl: a vector table for the basic flow plus
// hand-written sequences for budget stop, flush, abort, saturation and reset.
module tb_rle_capture_ctrl;

    localparam int LW  = 8;
    localparam int RES = 4;
    localparam int DC  = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          arm, abort, trigger, cfg_rle_en;
    logic [1:0]    cfg_rle_mode;
    logic [3:0]    cfg_groups;
    logic [LW-1:0] cfg_limit;
    logic [31:0]   sample_data;
    logic          sample_valid, enc_valid_out;
    logic          enc_enable;
    logic [1:0]    enc_mode;
    logic [3:0]    enc_groups;
    logic [31:0]   enc_data;
    logic          enc_valid, busy, done;
    logic [LW-1:0] word_count;
    logic [49:0]   outs;

    int total = 0;
    int bad   = 0;

    rle_capture_ctrl #(.LIMIT_W(LW), .RESERVE(RES), .DRAIN_CYCLES(DC)) dut (
        .clock(clock), .reset(reset), .arm(arm), .abort(abort), .trigger(trigger),
        .cfg_rle_en(cfg_rle_en), .cfg_rle_mode(cfg_rle_mode), .cfg_groups(cfg_groups),
        .cfg_limit(cfg_limit), .sample_data(sample_data), .sample_valid(sample_valid),
        .enc_valid_out(enc_valid_out), .enc_enable(enc_enable), .enc_mode(enc_mode),
        .enc_groups(enc_groups), .enc_data(enc_data), .enc_valid(enc_valid),
        .busy(busy), .done(done), .word_count(word_count)
    );

    assign outs = {enc_enable, enc_mode, enc_groups, enc_data, enc_valid, busy, done, word_count};

    always #5 clock = ~clock;

    typedef struct {
        logic arm, abort, trig, en;
        logic [1:0] mode;
        logic [3:0] grp;
        logic [LW-1:0] limit;
        logic [31:0] sdata;
        logic sv, evo;
        logic x_en, x_v;
        logic [31:0] x_data;
        logic [1:0] x_mode;
        logic [3:0] x_grp;
        logic x_busy, x_done;
        logic [LW-1:0] x_wc;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_in();
        arm = 1'b0; abort = 1'b0; trigger = 1'b0;
        sample_data = 32'h0; sample_valid = 1'b0; enc_valid_out = 1'b0;
    endtask

    task automatic do_arm(input logic en, input logic [1:0] mode, input logic [3:0] grp,
                          input logic [LW-1:0] lim);
        clr_in();
        arm = 1'b1; cfg_rle_en = en; cfg_rle_mode = mode; cfg_groups = grp; cfg_limit = lim;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk(name, 64'(done), 64'(1));
    endtask

    initial begin
        int n;
        logic found, pv, vseen, en_seen, stopped, sat_seen, fl_seen, wrap;
        logic [LW-1:0] pwc;

        tbl[0]  = '{1'b0,1'b0,1'b0,1'b1,2'd2,4'hE,8'd6,32'h0,  1'b0,1'b0, 1'b0,1'b0,32'h0,2'd0,4'h0,1'b0,1'b0,8'd0};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b1,2'd2,4'hE,8'd6,32'h11, 1'b1,1'b0, 1'b1,1'b0,32'h0,2'd2,4'hE,1'b1,1'b0,8'd0};
        tbl[2]  = '{1'b0,1'b0,1'b0,1'b1,2'd3,4'h0,8'd9,32'h41, 1'b1,1'b1, 1'b1,1'b1,32'h41,2'd2,4'hE,1'b1,1'b0,8'd0};
        tbl[3]  = '{1'b0,1'b0,1'b1,1'b1,2'd2,4'hE,8'd6,32'h42, 1'b1,1'b0, 1'b1,1'b1,32'h42,2'd2,4'hE,1'b1,1'b0,8'd0};
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,2'd2,4'hE,8'd6,32'h42, 1'b1,1'b1, 1'b1,1'b1,32'h42,2'd2,4'hE,1'b1,1'b0,8'd1};
        tbl[5]  = '{1'b0,1'b0,1'b0,1'b1,2'd2,4'hE,8'd6,32'h142,1'b1,1'b1, 1'b1,1'b1,32'h142,2'd2,4'hE,1'b1,1'b0,8'd2};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b1,2'd2,4'hE,8'd6,32'h99, 1'b1,1'b1, 1'b1,1'b1,32'hFFFFFEBD,2'd2,4'hE,1'b1,1'b0,8'd3};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b1,2'd2,4'hE,8'd6,32'h77, 1'b1,1'b0, 1'b1,1'b0,32'h0,2'd2,4'hE,1'b1,1'b0,8'd3};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b1,2'd2,4'hE,8'd6,32'h0,  1'b0,1'b1, 1'b1,1'b0,32'h0,2'd2,4'hE,1'b1,1'b0,8'd4};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,2'd2,4'hE,8'd6,32'h0,  1'b0,1'b0, 1'b1,1'b0,32'h0,2'd2,4'hE,1'b1,1'b0,8'd4};
        tbl[10] = '{1'b0,1'b0,1'b0,1'b1,2'd2,4'hE,8'd6,32'h0,  1'b0,1'b0, 1'b1,1'b0,32'h0,2'd2,4'hE,1'b1,1'b0,8'd4};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b1,2'd2,4'hE,8'd6,32'h0,  1'b0,1'b0, 1'b0,1'b0,32'h0,2'd2,4'hE,1'b0,1'b1,8'd4};
        tbl[12] = '{1'b0,1'b0,1'b1,1'b1,2'd2,4'hE,8'd6,32'h0,  1'b0,1'b0, 1'b0,1'b0,32'h0,2'd2,4'hE,1'b0,1'b1,8'd4};
        tbl[13] = '{1'b1,1'b0,1'b0,1'b0,2'd1,4'h0,8'd5,32'h0,  1'b0,1'b0, 1'b0,1'b0,32'h0,2'd1,4'h0,1'b1,1'b0,8'd0};
        tbl[14] = '{1'b0,1'b0,1'b0,1'b0,2'd1,4'h0,8'd5,32'hA,  1'b1,1'b0, 1'b0,1'b1,32'hA,2'd1,4'h0,1'b1,1'b0,8'd0};
        tbl[15] = '{1'b0,1'b0,1'b1,1'b0,2'd1,4'h0,8'd5,32'hB,  1'b1,1'b0, 1'b0,1'b1,32'hB,2'd1,4'h0,1'b1,1'b0,8'd0};
        tbl[16] = '{1'b0,1'b0,1'b0,1'b0,2'd1,4'h0,8'd5,32'hA,  1'b1,1'b1, 1'b0,1'b1,32'hA,2'd1,4'h0,1'b1,1'b0,8'd1};
        tbl[17] = '{1'b0,1'b0,1'b0,1'b0,2'd1,4'h0,8'd5,32'hB,  1'b1,1'b1, 1'b0,1'b0,32'h0,2'd1,4'h0,1'b1,1'b0,8'd2};
        tbl[18] = '{1'b0,1'b0,1'b0,1'b0,2'd1,4'h0,8'd5,32'h0,  1'b0,1'b0, 1'b0,1'b0,32'h0,2'd1,4'h0,1'b1,1'b0,8'd2};
        tbl[19] = '{1'b0,1'b0,1'b0,1'b0,2'd1,4'h0,8'd5,32'h0,  1'b0,1'b0, 1'b0,1'b0,32'h0,2'd1,4'h0,1'b1,1'b0,8'd2};
        tbl[20] = '{1'b0,1'b0,1'b0,1'b0,2'd1,4'h0,8'd5,32'h0,  1'b0,1'b0, 1'b0,1'b0,32'h0,2'd1,4'h0,1'b1,1'b0,8'd2};
        tbl[21] = '{1'b0,1'b0,1'b0,1'b0,2'd1,4'h0,8'd5,32'h0,  1'b0,1'b0, 1'b0,1'b0,32'h0,2'd1,4'h0,1'b0,1'b1,8'd2};
        tbl[22] = '{1'b1,1'b1,1'b0,1'b1,2'd2,4'hE,8'd6,32'h0,  1'b0,1'b0, 1'b0,1'b0,32'h0,2'd1,4'h0,1'b0,1'b0,8'd0};

        reset = 1'b1;
        clr_in();
        cfg_rle_en = 1'b0; cfg_rle_mode = 2'd0; cfg_groups = 4'h0; cfg_limit = '0;
        #2 reset = 1'b0;

        // reset held low with random activity on every input
        for (int i = 0; i < 10; i++) begin
            arm = 1'($urandom_range(0, 1)); abort = 1'($urandom_range(0, 1));
            trigger = 1'($urandom_range(0, 1)); cfg_rle_en = 1'($urandom_range(0, 1));
            cfg_rle_mode = 2'($urandom_range(0, 3)); cfg_groups = 4'($urandom_range(0, 15));
            cfg_limit = LW'($urandom_range(0, 255)); sample_data = $urandom();
            sample_valid = 1'($urandom_range(0, 1)); enc_valid_out = 1'($urandom_range(0, 1));
            tick();
            chk($sformatf("rst_outs_%0d", i), 64'(outs), 64'(0));
        end
        clr_in();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            trigger = 1'($urandom_range(0, 1)); sample_data = $urandom();
            sample_valid = 1'($urandom_range(0, 1)); enc_valid_out = 1'($urandom_range(0, 1));
            tick();
            chk($sformatf("idle_busy_%0d", i), 64'({busy, done, enc_enable, word_count}), 64'(0));
        end
        clr_in();

        for (int i = 0; i < NV; i++) begin
            arm = tbl[i].arm; abort = tbl[i].abort; trigger = tbl[i].trig;
            cfg_rle_en = tbl[i].en; cfg_rle_mode = tbl[i].mode; cfg_groups = tbl[i].grp;
            cfg_limit = tbl[i].limit; sample_data = tbl[i].sdata;
            sample_valid = tbl[i].sv; enc_valid_out = tbl[i].evo;
            tick();
            chk($sformatf("v%0d_en", i), 64'(enc_enable), 64'(tbl[i].x_en));
            chk($sformatf("v%0d_valid", i), 64'(enc_valid), 64'(tbl[i].x_v));
            if (tbl[i].x_v) chk($sformatf("v%0d_data", i), 64'(enc_data), 64'(tbl[i].x_data));
            chk($sformatf("v%0d_mode", i), 64'(enc_mode), 64'(tbl[i].x_mode));
            chk($sformatf("v%0d_grp", i), 64'(enc_groups), 64'(tbl[i].x_grp));
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'(tbl[i].x_busy));
            chk($sformatf("v%0d_done", i), 64'(done), 64'(tbl[i].x_done));
            chk($sformatf("v%0d_wc", i), 64'(word_count), 64'(tbl[i].x_wc));
        end
        clr_in();

        // limit 100: stop when word_count reaches 96, flush ~0x42
        do_arm(1'b1, 2'd1, 4'hE, 8'd100);
        trigger = 1'b1; sample_data = 32'h41; sample_valid = 1'b1; tick(); trigger = 1'b0;
        found = 1'b0; pv = 1'b0; pwc = '0; n = 0;
        while (!found && n < 300) begin
            pwc = word_count; pv = enc_valid;
            sample_data = 32'h42; sample_valid = 1'b1; enc_valid_out = 1'b1;
            tick();
            n++;
            if (enc_valid && enc_data == 32'hFFFFFFBD) found = 1'b1;
        end
        chk("B_flush_seen", 64'(found), 64'(1));
        chk("B_flush_wc", 64'(word_count), 64'(97));
        chk("B_prev_wc", 64'(pwc), 64'(96));
        chk("B_prev_valid", 64'(pv), 64'(1));
        n = 0; vseen = 1'b0;
        while (!done && n < 20) begin
            tick();
            n++;
            if (enc_valid) vseen = 1'b1;
        end
        chk("B_done_latency", 64'(n), 64'(DC + 1));
        chk("B_drain_novalid", 64'(vseen), 64'(0));
        chk("B_final_wc", 64'(word_count), 64'(102));

        // rle disabled, alternating data: straight to DRAIN
        do_arm(1'b0, 2'd0, 4'hE, 8'd20);
        trigger = 1'b1; sample_data = 32'h1; sample_valid = 1'b1; tick(); trigger = 1'b0;
        en_seen = enc_enable; stopped = 1'b0; n = 0;
        while (!stopped && n < 100) begin
            sample_data = (n % 2 == 1) ? 32'h1 : 32'h2; sample_valid = 1'b1; enc_valid_out = 1'b1;
            tick();
            n++;
            if (enc_enable) en_seen = 1'b1;
            if (!enc_valid) stopped = 1'b1;
        end
        chk("C_stopped", 64'(stopped), 64'(1));
        chk("C_stop_wc", 64'(word_count), 64'(17));
        chk("C_busy", 64'(busy), 64'(1));
        for (int k = 0; k < 3; k++) begin
            tick();
            if (enc_enable || enc_valid) en_seen = 1'b1;
        end
        chk("C_not_done_yet", 64'(done), 64'(0));
        tick();
        chk("C_done", 64'(done), 64'(1));
        chk("C_done_wc", 64'(word_count), 64'(21));
        chk("C_enable_never", 64'(en_seen), 64'(0));

        // upper lanes masked: 0xFFFFAA55 repeats 0x0000AA55
        do_arm(1'b1, 2'd2, 4'hC, 8'd6);
        trigger = 1'b1; sample_data = 32'h0000AA55; sample_valid = 1'b1; tick(); trigger = 1'b0;
        sample_data = 32'hFFFFAA55; enc_valid_out = 1'b1; tick();
        chk("D_fwd", 64'(enc_data), 64'(32'hFFFFAA55));
        sample_valid = 1'b0; tick();
        chk("D_wc", 64'(word_count), 64'(2));
        tick();
        chk("D_flush_valid", 64'(enc_valid), 64'(1));
        chk("D_flush_data", 64'(enc_data), 64'(32'h000055AA));
        chk("D_groups", 64'(enc_groups), 64'(4'hC));
        wait_done("D_done");

        // abort in RUN
        do_arm(1'b1, 2'd0, 4'hE, 8'd100);
        trigger = 1'b1; sample_valid = 1'b1; sample_data = 32'h5; tick(); trigger = 1'b0;
        enc_valid_out = 1'b1; tick(); tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("E_abort_state", 64'({busy, done, enc_enable, enc_valid}), 64'(0));
        chk("E_abort_wc", 64'(word_count), 64'(0));
        tick(); tick(); tick();
        chk("E_abort_stays", 64'({busy, done}), 64'(0));
        // trigger and abort together in ARMED
        do_arm(1'b1, 2'd0, 4'hE, 8'd100);
        chk("E_armed_busy", 64'(busy), 64'(1));
        trigger = 1'b1; abort = 1'b1; tick(); clr_in();
        chk("E_trig_abort", 64'({busy, enc_enable}), 64'(0));
        arm = 1'b1; abort = 1'b1; tick(); clr_in();
        chk("E_arm_abort", 64'({busy, done, enc_enable}), 64'(0));

        // limit below reserve: one RUN cycle then DRAIN
        do_arm(1'b0, 2'd0, 4'hE, 8'd3);
        trigger = 1'b1; sample_data = 32'h5; sample_valid = 1'b1; tick(); trigger = 1'b0;
        chk("F_armed_fwd", 64'(enc_valid), 64'(1));
        sample_data = 32'h6; enc_valid_out = 1'b1; tick();
        chk("F_no_fwd", 64'(enc_valid), 64'(0));
        chk("F_busy", 64'(busy), 64'(1));
        chk("F_wc", 64'(word_count), 64'(1));
        wait_done("F_done");

        // saturation of word_count at all-ones
        do_arm(1'b1, 2'd0, 4'hE, 8'hFF);
        trigger = 1'b1; sample_data = 32'h33; sample_valid = 1'b1; tick(); trigger = 1'b0;
        sat_seen = 1'b0; fl_seen = 1'b0; wrap = 1'b0; n = 0;
        while (!done && n < 400) begin
            pwc = word_count;
            sample_data = 32'h33; sample_valid = 1'b1; enc_valid_out = 1'b1;
            tick();
            n++;
            if (busy && word_count == 8'hFF) sat_seen = 1'b1;
            if (enc_valid && enc_data == 32'hFFFFFFCC) fl_seen = 1'b1;
            if (word_count < pwc) wrap = 1'b1;
        end
        chk("G_done", 64'(done), 64'(1));
        chk("G_wc_sat", 64'(word_count), 64'(8'hFF));
        chk("G_sat_busy", 64'(sat_seen), 64'(1));
        chk("G_flush", 64'(fl_seen), 64'(1));
        chk("G_no_wrap", 64'(wrap), 64'(0));

        // asynchronous reset mid-acquisition
        do_arm(1'b1, 2'd3, 4'h5, 8'd100);
        trigger = 1'b1; sample_valid = 1'b1; sample_data = 32'h9; tick(); trigger = 1'b0;
        enc_valid_out = 1'b1; tick();
        chk("H_running", 64'({busy, enc_enable}), 64'(2'b11));
        #2 reset = 1'b0;
        #1;
        chk("H_async_clear", 64'(outs), 64'(0));
        tick();
        reset = 1'b1;
        tick();
        chk("H_after_release", 64'({busy, done, enc_valid, enc_enable}), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rle_capture_ctrl.md
# rle_capture_ctrl

Capture-side controller that sequences the `rle_enc` run-length encoder for one acquisition. It latches the RLE configuration, forwards sampler data into the encoder, and counts encoder output words against a post-trigger budget. When the budget is reached it closes any open run by injecting a terminating sample, drains the encoder pipeline, and then drops the encoder enable. It sits between the sampler/trigger logic and `rle_enc`; the encoder output goes straight to sample memory.

## Interface
- `LIMIT_W`, 16: width of the word budget and the word counter.
- `RESERVE`, 4: words held back from the budget for the flush and drain (≥2).
- `DRAIN_CYCLES`, 4: cycles `enc_enable` stays high after the last injected sample (≥ encoder latency).

- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low; all state cleared while low.
- `arm` in 1: single-cycle pulse; starts an acquisition from IDLE or DONE.
- `abort` in 1: synchronous abort from any state.
- `trigger` in 1: trigger fired; sampled in ARMED only.
- `cfg_rle_en` in 1, `cfg_rle_mode` in 2, `cfg_groups` in 4, `cfg_limit` in LIMIT_W: configuration, latched on an accepted `arm`.
- `sample_data` in 32, `sample_valid` in 1: sampler stream.
- `enc_valid_out` in 1: `validOut` from `rle_enc`.
- `enc_enable` out 1, `enc_mode` out 2, `enc_groups` out 4: `rle_enc` control.
- `enc_data` out 32, `enc_valid` out 1: `rle_enc` `dataIn` and `validIn`.
- `busy` out 1, `done` out 1, `word_count` out LIMIT_W: status.

## Operation
- States: IDLE, ARMED, RUN, FLUSH, DRAIN, DONE.
- IDLE → ARMED on `arm`. On that edge, latch the cfg inputs and clear `word_count` and the run flag. An `arm` in DONE behaves identically. An `arm` in any other state is ignored.
- ARMED: forward samples (`enc_valid`=`sample_valid`, `enc_data`=`sample_data`). `enc_enable`=latched `cfg_rle_en`. `word_count` does not count. `trigger` → RUN.
- RUN: keep forwarding. `word_count` += 1 on each `enc_valid_out`, saturating at all-ones. Stop condition: `word_count` + RESERVE ≥ latched limit, evaluated in LIMIT_W+1 bits with no underflow. On stop:
  - if `cfg_rle_en` and `run_open` → FLUSH;
  - otherwise → DRAIN.
  - Forwarding ends on the same edge.
- Run tracking: mask = byte lanes whose `cfg_groups` bit is 0. On each forwarded valid sample:
  - `run_open` = 1 if the masked sample equals the masked `last_data`, else 0;
  - `last_data` is then updated to the sample.
- FLUSH: exactly one cycle with `enc_valid`=1 and `enc_data`=~`last_data`. This forces the encoder to emit the pending run count. Next state is DRAIN.
- DRAIN: `enc_valid`=0 and `enc_enable` held for DRAIN_CYCLES cycles; `word_count` keeps counting. Next state is DONE.
- DONE: `enc_enable`=0, `done`=1, `busy`=0. Stays until `arm` or `abort`.
- `abort`: next edge goes to IDLE with `enc_enable`=0, `enc_valid`=0, `word_count`=0, `done`=0. It beats `arm` in the same cycle.
- `busy`=1 in ARMED, RUN, FLUSH, and DRAIN.
- `enc_mode` and `enc_groups` always drive the latched values.

## Timing
- Reset values: all outputs 0, state IDLE, `last_data`=0, `run_open`=0.
- All outputs are registered. A sample seen at edge N appears on `enc_data`/`enc_valid` after edge N, i.e. 1-cycle latency.
- `trigger` high at edge N in ARMED: RUN after N. `enc_valid_out` counts from edge N+1.
- Stop detected at edge N: FLUSH occupies cycle N+1, DRAIN cycles N+2..N+1+DRAIN_CYCLES, then DONE. Without a flush everything is one cycle earlier.
- Stop reached on the first RUN cycle (limit ≤ RESERVE): proceed to FLUSH or DRAIN after one RUN cycle.
- A sample and the stop condition on the same edge: the sample is not forwarded.
- `trigger` and `abort` on the same edge: abort wins.
- `reset` low mid-acquisition: outputs clear immediately, without waiting for a clock. No flush is issued.

## Test plan
- Reset low for 10 cycles with random inputs → every output stays 0. After release the block stays in IDLE until `arm`.
- Arm with `cfg_rle_en`=1, groups=4'b1110, limit=100. Trigger, then stream 0x41 ×1 followed by 0x42 ×200 → `enc_valid` drops after `word_count`=96. One FLUSH cycle drives `enc_data`=~0x42 on lanes 7:0. `done` rises DRAIN_CYCLES+1 cycles later.
- Same test with `cfg_rle_en`=0 and alternating data → no FLUSH cycle. `enc_enable`=0 throughout. DRAIN and then DONE follow the stop condition.
- Groups=4'b1100, samples 0x0000AA55 then 0xFFFFAA55 at the stop point → counted as a repeat (upper lanes masked), so FLUSH occurs.
- Assert `abort` in RUN and, separately, `arm`+`abort` together → IDLE next cycle, `word_count`=0, `enc_enable`=0, no `done`.
- Limit=3 with RESERVE=4 → stop is taken on the first RUN cycle. Check `word_count` saturation at 0xFFFF with limit=0xFFFF and RESERVE=0-equivalent stimulus.
